// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 channel mux with an auto-scan mode that walks channels
// from a start index to an inclusive end index, with wrap-around and stall.
module mux_nto1_scan #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [(2**SEL_W)*WIDTH-1:0]    in_bus,
  input  logic [SEL_W-1:0]               sel,
  input  logic [SEL_W-1:0]               last,
  input  logic                           mode,
  input  logic                           en,
  input  logic                           start,
  output logic [WIDTH-1:0]               z,
  output logic [SEL_W-1:0]               z_idx,
  output logic                           z_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned N = 2 ** SEL_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_idx, w_idx_nxt;
  logic [SEL_W-1:0]   r_last, w_last_nxt;
  logic [WIDTH-1:0]   r_z, w_z_nxt;
  logic [SEL_W-1:0]   r_z_idx, w_z_idx_nxt;
  logic               r_z_valid, w_z_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  logic [WIDTH-1:0]   w_ch [N];
  logic [SEL_W-1:0]   w_sel_idx;
  logic [WIDTH-1:0]   w_sel_data;

  // Unpack the flat bus into addressable channels.
  for (genvar g = 0; g < int'(N); g++) begin : g_unpack
    assign w_ch[g] = in_bus[g*WIDTH +: WIDTH];
  end

  // Scan counter drives the mux while scanning; external select otherwise.
  assign w_sel_idx  = (r_state == S_SCAN) ? r_idx : sel;
  assign w_sel_data = w_ch[w_sel_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_last    <= '0;
      r_z       <= '0;
      r_z_idx   <= '0;
      r_z_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_last    <= w_last_nxt;
      r_z       <= w_z_nxt;
      r_z_idx   <= w_z_idx_nxt;
      r_z_valid <= w_z_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_last_nxt    = r_last;
    w_z_nxt       = r_z;
    w_z_idx_nxt   = r_z_idx;
    w_z_valid_nxt = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!mode) begin
          if (en) begin
            w_z_nxt       = w_sel_data;
            w_z_idx_nxt   = sel;
            w_z_valid_nxt = 1'b1;
          end
        end else if (start) begin
          w_state_nxt = S_SCAN;
          w_idx_nxt   = sel;
          w_last_nxt  = last;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SCAN: begin
        // en low stalls the walk with z/z_idx held.
        if (en) begin
          w_z_nxt       = w_sel_data;
          w_z_idx_nxt   = r_idx;
          w_z_valid_nxt = 1'b1;
          if (r_idx == r_last) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = SEL_W'(r_idx + SEL_W'(1));
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign z       = r_z;
  assign z_idx   = r_z_idx;
  assign z_valid = r_z_valid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: directed table, hand sequences for stall and
// reset corners, then random traffic against a queue-based beat model.
module tb_mux_nto1_scan;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned N  = 16;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [N*W-1:0]     in_bus;
  logic [SW-1:0]      sel, last;
  logic               mode, en, start;
  logic [W-1:0]       z;
  logic [SW-1:0]      z_idx;
  logic               z_valid, busy, done;

  int n_vec = 0;
  int n_err = 0;
  bit rnd_bus = 1'b0;

  // Model: a queue of channel indices still to be emitted by the current scan.
  int         m_q[$];
  logic [W-1:0]  m_z;
  logic [SW-1:0] m_zi;
  logic          m_v, m_b, m_d;

  mux_nto1_scan #(.WIDTH(W), .SEL_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .in_bus(in_bus), .sel(sel), .last(last),
    .mode(mode), .en(en), .start(start), .z(z), .z_idx(z_idx),
    .z_valid(z_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          m, e, s;
    logic [SW-1:0] sl, ls;
    logic [W-1:0]  ez;
    logic [SW-1:0] ei;
    logic          ev, eb, ed;
  } vec_t;

  function automatic logic [W-1:0] chan(input int k);
    return in_bus[k*W +: W];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_z = '0; m_zi = '0; m_v = 1'b0; m_b = 1'b0; m_d = 1'b0;
  endtask

  task automatic model_step();
    int k, cnt;
    m_v = 1'b0;
    m_d = 1'b0;
    if (m_q.size() != 0) begin
      if (en) begin
        k = m_q.pop_front();
        m_z = chan(k); m_zi = SW'(k); m_v = 1'b1;
        if (m_q.size() == 0) m_d = 1'b1;
      end
    end else if (!mode) begin
      if (en) begin
        m_z = chan(int'(sel)); m_zi = sel; m_v = 1'b1;
      end
    end else if (start) begin
      cnt = ((int'(last) - int'(sel) + int'(N)) % int'(N)) + 1;
      for (int b = 0; b < cnt; b++) m_q.push_back((int'(sel) + b) % int'(N));
    end
    m_b = (m_q.size() != 0);
  endtask

  task automatic cmp(input string nm, input logic [W-1:0] ez, input logic [SW-1:0] ei,
                     input logic ev, input logic eb, input logic ed);
    n_vec++;
    if ({z, z_idx, z_valid, busy, done} !== {ez, ei, ev, eb, ed}) begin
      n_err++;
      $display("FAIL %s: got z=%h idx=%0d v=%b busy=%b done=%b, want z=%h idx=%0d v=%b busy=%b done=%b",
               nm, z, z_idx, z_valid, busy, done, ez, ei, ev, eb, ed);
    end
  endtask

  // Apply inputs at negedge, advance one edge, update model, compare after the edge.
  task automatic drive(input string nm, input logic m, input logic e, input logic s,
                       input logic [SW-1:0] sl, input logic [SW-1:0] ls);
    @(negedge clk);
    mode = m; en = e; start = s; sel = sl; last = ls;
    if (rnd_bus)
      for (int k = 0; k < int'(N); k++) in_bus[k*W +: W] = $urandom;
    @(posedge clk);
    model_step();
    #1;
    cmp(nm, m_z, m_zi, m_v, m_b, m_d);
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b0,1'b1,1'b0, 4'd5, 4'd0, 32'h1005, 4'd5, 1'b1,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0, 4'd5, 4'd0, 32'h1005, 4'd5, 1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b1, 4'd2, 4'd5, 32'h1005, 4'd5, 1'b0,1'b1,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h1002, 4'd2, 1'b1,1'b1,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h1003, 4'd3, 1'b1,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h1004, 4'd4, 1'b1,1'b1,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h1005, 4'd5, 1'b1,1'b0,1'b1};
    tbl[7]  = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h1005, 4'd5, 1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b1, 4'd14,4'd1, 32'h1005, 4'd5, 1'b0,1'b1,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h100e, 4'd14,1'b1,1'b1,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h100f, 4'd15,1'b1,1'b1,1'b0};
    tbl[11] = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h1000, 4'd0, 1'b1,1'b1,1'b0};
    tbl[12] = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h1001, 4'd1, 1'b1,1'b0,1'b1};
    tbl[13] = '{1'b1,1'b1,1'b1, 4'd9, 4'd9, 32'h1001, 4'd1, 1'b0,1'b1,1'b0};
    tbl[14] = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h1009, 4'd9, 1'b1,1'b0,1'b1};
    tbl[15] = '{1'b1,1'b1,1'b0, 4'd0, 4'd0, 32'h1009, 4'd9, 1'b0,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b1,1'b1, 4'd7, 4'd3, 32'h1007, 4'd7, 1'b1,1'b0,1'b0};

    reset_n = 1'b0;
    mode = 1'b0; en = 1'b0; start = 1'b0; sel = '0; last = '0;
    for (int k = 0; k < int'(N); k++) in_bus[k*W +: W] = 32'h1000 + W'(k);
    model_reset();
    repeat (3) @(posedge clk);
    #1 cmp("reset_held", '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    #1 cmp("reset_rel", '0, '0, 1'b0, 1'b0, 1'b0);

    // Directed table: spec-derived constants, cross-checked against the model.
    for (int i = 0; i < 17; i++) begin
      drive($sformatf("tbl%0d_model", i), tbl[i].m, tbl[i].e, tbl[i].s, tbl[i].sl, tbl[i].ls);
      cmp($sformatf("tbl%0d", i), tbl[i].ez, tbl[i].ei, tbl[i].ev, tbl[i].eb, tbl[i].ed);
    end

    // Full scan: last = sel - 1 gives all 16 channels ending at idx 2.
    drive("full_launch", 1'b1, 1'b1, 1'b1, 4'd3, 4'd2);
    for (int i = 0; i < 16; i++) begin
      drive($sformatf("full_beat%0d", i), 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      if (i == 14) cmp("full_not_done", 32'h1001, 4'd1, 1'b1, 1'b1, 1'b0);
    end
    cmp("full_end", 32'h1002, 4'd2, 1'b1, 1'b0, 1'b1);

    // Stall at idx 3 while poking start/last/sel; scan must still end at 7.
    drive("stall_launch", 1'b1, 1'b1, 1'b1, 4'd0, 4'd7);
    for (int i = 0; i < 4; i++) drive("stall_pre", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      drive("stall_model", 1'b0, 1'b0, 1'b1, 4'd12, 4'd1);
      cmp($sformatf("stall_hold%0d", i), 32'h1003, 4'd3, 1'b0, 1'b1, 1'b0);
    end
    drive("resume4", 1'b1, 1'b1, 1'b0, 4'd0, 4'd1);
    cmp("resume_idx4", 32'h1004, 4'd4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive("resume_model", 1'b1, 1'b1, 1'b0, 4'd0, 4'd1);
    cmp("stall_end7", 32'h1007, 4'd7, 1'b1, 1'b0, 1'b1);

    // Async reset mid-scan at idx 6.
    drive("rst_launch", 1'b1, 1'b1, 1'b1, 4'd0, 4'd15);
    for (int i = 0; i < 7; i++) drive("rst_pre", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    cmp("rst_at6", 32'h1006, 4'd6, 1'b1, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1 cmp("rst_async", '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive("post_rst_model", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      cmp("post_rst_idle", '0, '0, 1'b0, 1'b0, 1'b0);
    end

    // Random traffic against the model.
    rnd_bus = 1'b1;
    for (int i = 0; i < 400; i++)
      drive($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), SW'($urandom), SW'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
